// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter sharing one serial restoring divider among REQ_NUM requesters
// Optional feature macro: DIV_ZERO_CHECK_EN (zero divisor bypasses the divider, flags dz_err_o)
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_i                      per-requester level request, held until its ack bit
//   dividend_i, divisor_i      packed operands, requester i at [i*M +: M] / [i*N +: N]
//   ack_o                      one-hot, one-cycle completion pulse
//   quotient_o, dz_err_o       result and divide-by-zero flag, valid with ack_o
//   busy_o, grant_id_o         FSM not idle, index of current/last granted requester
//   div_en_o, div_dividend_o,
//   div_divisor_o              drive the divider (operands held LOAD through DONE)
//   div_quotient_i, div_ok_i   divider result and completion
module div_arbiter #(
    parameter int M       = 26,
    parameter int N       = 14,
    parameter int REQ_NUM = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REQ_NUM-1:0]   req_i,
    input  logic [REQ_NUM*M-1:0] dividend_i,
    input  logic [REQ_NUM*N-1:0] divisor_i,
    output logic [REQ_NUM-1:0]   ack_o,
    output logic [M-1:0]         quotient_o,
    output logic                 dz_err_o,
    output logic                 busy_o,
    output logic [2:0]           grant_id_o,
    output logic                 div_en_o,
    output logic [M-1:0]         div_dividend_o,
    output logic [N-1:0]         div_divisor_o,
    input  logic [M-1:0]         div_quotient_i,
    input  logic                 div_ok_i
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t             state_q;
    logic [REQ_NUM-1:0] ack_q;
    logic [M-1:0]       quot_q;
    logic               dz_q;
    logic [2:0]         grant_q;
    logic               div_en_q;
    logic [M-1:0]       dvd_q;
    logic [N-1:0]       dvs_q;
    logic [7:0]         req_x;
    logic [3:0]         idx;
    logic [2:0]         pick;
    logic               hit;
    assign req_x = 8'(req_i);
    // Scan offsets from farthest to nearest so the requester closest after
    // the last grant overwrites the others; offset REQ_NUM is the last grantee.
    always_comb begin
        pick = grant_q;
        hit  = 1'b0;
        idx  = '0;
        for (int k = REQ_NUM; k >= 1; k--) begin
            idx = {1'b0, grant_q} + 4'(k);
            idx = (idx >= 4'(REQ_NUM)) ? idx - 4'(REQ_NUM) : idx;
            if (req_x[idx[2:0]]) begin
                pick = idx[2:0];
                hit  = 1'b1;
            end
        end
    end
    // The zero-operand bypass is decided in LOAD on the latched operands, so
    // a bypassed request acks one clock after the grant without enabling the divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ack_q    <= '0;
            quot_q   <= '0;
            dz_q     <= 1'b0;
            grant_q  <= 3'(REQ_NUM - 1);
            div_en_q <= 1'b0;
            dvd_q    <= '0;
            dvs_q    <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: if (hit) begin
                    grant_q <= pick;
                    dvd_q   <= dividend_i[int'(pick)*M +: M];
                    dvs_q   <= divisor_i[int'(pick)*N +: N];
                    state_q <= LOAD;
                end
                LOAD: begin
                    if (dvd_q == '0) begin
                        quot_q  <= '0;
                        dz_q    <= 1'b0;
                        ack_q   <= REQ_NUM'(1) << grant_q;
                        state_q <= DONE;
                    end
`ifdef DIV_ZERO_CHECK_EN
                    else if (dvs_q == '0) begin
                        quot_q  <= '1;
                        dz_q    <= 1'b1;
                        ack_q   <= REQ_NUM'(1) << grant_q;
                        state_q <= DONE;
                    end
`endif
                    else begin
                        div_en_q <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: if (div_ok_i) begin
                    quot_q   <= div_quotient_i;
                    dz_q     <= 1'b0;
                    ack_q    <= REQ_NUM'(1) << grant_q;
                    div_en_q <= 1'b0;
                    state_q  <= DONE;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign ack_o          = ack_q;
    assign quotient_o     = quot_q;
    assign dz_err_o       = dz_q;
    assign busy_o         = state_q != IDLE;
    assign grant_id_o     = grant_q;
    assign div_en_o       = div_en_q;
    assign div_dividend_o = dvd_q;
    assign div_divisor_o  = dvs_q;
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed scoreboard bench for div_arbiter with a behavioural divider
module tb_div_arbiter;
    localparam int M = 26;
    localparam int N = 14;
    localparam int R = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [R-1:0]   req = '0;
    logic [R*M-1:0] dividend = '0;
    logic [R*N-1:0] divisor = '0;
    logic [R-1:0]   ack;
    logic [M-1:0]   quotient;
    logic           dz_err;
    logic           busy;
    logic [2:0]     grant_id;
    logic           div_en;
    logic [M-1:0]   div_dividend;
    logic [N-1:0]   div_divisor;
    logic [M-1:0]   div_quotient = '0;
    logic           div_ok = 1'b0;
    logic [5:0]     dcnt = '0;
    int tests = 0;
    int fails = 0;
    int opn = 0;
    typedef struct {
        int           num;
        int           id;
        logic [M-1:0] q;
        logic         dz;
        int           lat;
        logic         noen;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    div_arbiter #(.M(M), .N(N), .REQ_NUM(R)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .dividend_i(dividend), .divisor_i(divisor),
        .ack_o(ack), .quotient_o(quotient), .dz_err_o(dz_err), .busy_o(busy),
        .grant_id_o(grant_id), .div_en_o(div_en), .div_dividend_o(div_dividend),
        .div_divisor_o(div_divisor), .div_quotient_i(div_quotient), .div_ok_i(div_ok)
    );

    // Divider model: clears while en is low, raises ok after M+1 enabled edges.
    always @(posedge clk) begin
        if (!div_en) begin
            dcnt   <= '0;
            div_ok <= 1'b0;
        end else if (!div_ok) begin
            if (dcnt == 6'(M)) begin
                div_ok       <= 1'b1;
                div_quotient <= (div_divisor == '0) ? '1 : div_dividend / M'(div_divisor);
            end
            dcnt <= dcnt + 6'd1;
        end
    end

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(int i, logic [M-1:0] a, logic [N-1:0] b);
        dividend[i*M +: M] = a;
        divisor[i*N +: N]  = b;
    endtask

    task automatic push(int id, logic [M-1:0] q, logic dz, int lat, logic noen);
        exp_t e;
        e.num = opn; e.id = id; e.q = q; e.dz = dz; e.lat = lat; e.noen = noen;
        opn++;
        sb.push_back(e);
    endtask

    task automatic check_reset(string tag);
        check({tag, "_ack"}, 64'(ack), 0);
        check({tag, "_quot"}, 64'(quotient), 0);
        check({tag, "_dz"}, 64'(dz_err), 0);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_grant"}, 64'(grant_id), R - 1);
        check({tag, "_en"}, 64'(div_en), 0);
        check({tag, "_dvd"}, 64'(div_dividend), 0);
        check({tag, "_dvs"}, 64'(div_divisor), 0);
    endtask

    // Waits (bounded) for the next ack, compares it with the scoreboard head,
    // then drops the acked request bit. chg>0 scrambles dividend inputs on that cycle.
    task automatic wait_ack(int chg);
        exp_t e;
        int n = 0;
        logic en_seen = 1'b0;
        e = sb.pop_front();
        do begin
            @(negedge clk);
            n++;
            if (div_en === 1'b1) en_seen = 1'b1;
            if (n == chg) dividend = ~dividend;
        end while (ack === '0 && n < 100);
        check($sformatf("op%0d_ack", e.num), 64'(ack), 64'(R'(1) << e.id));
        check($sformatf("op%0d_quot", e.num), 64'(quotient), 64'(e.q));
        check($sformatf("op%0d_dz", e.num), 64'(dz_err), 64'(e.dz));
        check($sformatf("op%0d_en_done", e.num), 64'(div_en), 0);
        if (e.lat >= 0) check($sformatf("op%0d_lat", e.num), 64'(n - 1), 64'(e.lat));
        if (e.noen) check($sformatf("op%0d_noen", e.num), 64'(en_seen), 0);
        req = req & ~ack;
    endtask

    initial begin
        logic seen;
        #1 rst_n = 1'b0;
        #1 check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // Contention: all four held, order 0,1,2,3
        for (int i = 0; i < R; i++) begin
            set_op(i, M'(1000 + i * 111), N'(i + 2));
            push(i, M'((1000 + i * 111) / (i + 2)), 1'b0, (i == 0) ? M + 3 : -1, 1'b0);
        end
        req = '1;
        for (int i = 0; i < R; i++) wait_ack(-1);
        // Re-raise 0 and 2 after grant wrapped to 3: order 0,2
        set_op(0, 26'd900, 14'd9);
        set_op(2, 26'd5000, 14'd7);
        push(0, 26'd100, 1'b0, -1, 1'b0);
        push(2, 26'd714, 1'b0, -1, 1'b0);
        @(negedge clk);
        req = 4'b0101;
        wait_ack(-1);
        wait_ack(-1);
        // Single request 1000/7, busy drops after DONE
        @(negedge clk);
        set_op(0, 26'd1000, 14'd7);
        push(0, 26'd142, 1'b0, M + 3, 1'b0);
        req = 4'b0001;
        wait_ack(-1);
        check("done_busy", 64'(busy), 1);
        @(negedge clk);
        check("idle_busy", 64'(busy), 0);
        // Zero dividend bypass
        set_op(1, 26'd0, 14'd5);
        push(1, 26'd0, 1'b0, 1, 1'b1);
        req = 4'b0010;
        wait_ack(-1);
        @(negedge clk);
        // Zero divisor
        set_op(2, 26'd12345, 14'd0);
`ifdef DIV_ZERO_CHECK_EN
        push(2, 26'h3FFFFFF, 1'b1, 1, 1'b1);
`else
        push(2, 26'h3FFFFFF, 1'b0, M + 3, 1'b0);
`endif
        req = 4'b0100;
        wait_ack(-1);
        @(negedge clk);
        // 0/0 always takes the quotient-0 bypass
        set_op(3, 26'd0, 14'd0);
        push(3, 26'd0, 1'b0, 1, 1'b1);
        req = 4'b1000;
        wait_ack(-1);
        @(negedge clk);
        // Maximum operands, inputs scrambled mid-RUN
        set_op(0, 26'h3FFFFFF, 14'h3FFF);
        push(0, 26'd4096, 1'b0, M + 3, 1'b0);
        req = 4'b0001;
        wait_ack(10);
        @(negedge clk);
        // Asynchronous reset mid-RUN
        set_op(1, 26'd777, 14'd5);
        req = 4'b0010;
        repeat (10) @(negedge clk);
        check("mid_busy", 64'(busy), 1);
        check("mid_en", 64'(div_en), 1);
        #1 rst_n = 1'b0;
        #1 check_reset("midrst");
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ack !== '0) seen = 1'b1;
        end
        check("rst_noack", 64'(seen), 0);
        // Recovery: 500/3 with normal latency
        set_op(1, 26'd500, 14'd3);
        push(1, 26'd166, 1'b0, M + 3, 1'b0);
        req = 4'b0010;
        wait_ack(-1);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
